// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve slice: the branch opcode, the
// funct3 encodings, the 2-bit history counter states and the counter update.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_e;

  // Saturating step of a 2-bit direction counter.
  function automatic bht_cnt_e bht_cnt_next(input bht_cnt_e c, input logic taken);
    bht_cnt_e n;
    n = c;
    case (c)
      CNT_SNT: n = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: n = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  n = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  n = taken ? CNT_ST  : CNT_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluation (combinational).
//   funct3  : branch funct3 field
//   rs1/rs2 : compare operands, full XLEN
//   taken   : condition result (0 for reserved encodings)
//   illegal : funct3 is a reserved branch encoding (010 / 011)
module branch_compare
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3_e'(funct3))
      F3_BEQ:           taken   = (rs1 == rs2);
      F3_BNE:           taken   = (rs1 != rs2);
      F3_BLT:           taken   = ($signed(rs1) <  $signed(rs2));
      F3_BGE:           taken   = ($signed(rs1) >= $signed(rs2));
      F3_BLTU:          taken   = (rs1 <  rs2);
      F3_BGEU:          taken   = (rs1 >= rs2);
      F3_RSV2, F3_RSV3: illegal = 1'b1;
      default:          taken   = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, registers the result,
// trains a flop-based table of 2-bit direction counters and counts
// mispredicts (saturating).
//   clk, rst_n        : clock, asynchronous active-low reset
//   lk_pc / lk_taken  : fetch-side lookup, combinational prediction
//   br_*              : resolve request (valid, pc, opcode, funct3, operands, prediction)
//   res_*             : registered resolve result
//   mp_count          : saturating mispredict count
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [6:0]       br_opcode,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_rs1,
  input  logic [XLEN-1:0]  br_rs2,
  input  logic             br_pred,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] br_idx;
  logic             cond_taken;
  logic             cond_illegal;
  logic             upd_en;
  logic             unused_pc_bits;

  bht_cnt_e         bht_q [BHT_DEPTH];
  bht_cnt_e         bht_d [BHT_DEPTH];

  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic             res_illegal_q, res_illegal_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign br_idx = br_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                            br_pc[XLEN-1:IDX_W+2], br_pc[1:0]};

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3  (br_funct3),
    .rs1     (br_rs1),
    .rs2     (br_rs2),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    res_valid_d      = br_valid && (br_opcode == OPC_BRANCH);
    res_illegal_d    = res_valid_d && cond_illegal;
    upd_en           = res_valid_d && !cond_illegal;
    res_taken_d      = upd_en && cond_taken;
    res_mispredict_d = upd_en && (cond_taken ^ br_pred);

    mp_count_d = mp_count_q;
    if (res_mispredict_d && (mp_count_q != '1)) mp_count_d = mp_count_q + CNT_W'(1);

    bht_d = bht_q;
    if (upd_en) bht_d[br_idx] = bht_cnt_next(bht_q[br_idx], cond_taken);
  end

  // Reading the next-state table gives the same-cycle bypass for free:
  // bht_d equals bht_q everywhere except the entry being updated.
  assign lk_taken = bht_d[lk_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q            <= '{default: CNT_WNT};
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      mp_count_q       <= '0;
    end else begin
      bht_q            <= bht_d;
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_illegal_q    <= res_illegal_d;
      mp_count_q       <= mp_count_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_illegal    = res_illegal_q;
  assign mp_count       = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [31:0] PC_A = 32'h0000_0104; // idx 1
  localparam logic [31:0] PC_B = 32'h0000_0208; // idx 2
  localparam logic [31:0] PC_C = 32'h0000_040C; // idx 3
  localparam logic [31:0] PC_D = 32'h0000_0110; // idx 4

  logic        clk;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [6:0]  br_opcode;
  logic [2:0]  br_funct3;
  logic [31:0] br_rs1, br_rs2;
  logic        br_pred;

  logic        lk_taken, res_valid, res_taken, res_mispredict, res_illegal;
  logic [15:0] mp_count;
  logic        s_lk_taken, s_res_valid, s_res_taken, s_res_mispredict, s_res_illegal;
  logic [1:0]  s_mp_count;

  int unsigned n_checks;
  int unsigned n_fail;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .br_valid(br_valid), .br_pc(br_pc), .br_opcode(br_opcode), .br_funct3(br_funct3),
    .br_rs1(br_rs1), .br_rs2(br_rs2), .br_pred(br_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_illegal(res_illegal), .mp_count(mp_count)
  );

  branch_resolve_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(s_lk_taken),
    .br_valid(br_valid), .br_pc(br_pc), .br_opcode(br_opcode), .br_funct3(br_funct3),
    .br_rs1(br_rs1), .br_rs2(br_rs2), .br_pred(br_pred),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_mispredict(s_res_mispredict),
    .res_illegal(s_res_illegal), .mp_count(s_mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic pred);
    br_valid  = 1'b1;
    br_opcode = opc;
    br_funct3 = f3;
    br_rs1    = a;
    br_rs2    = b;
    br_pc     = pc;
    br_pred   = pred;
  endtask

  // res_valid, res_taken, res_mispredict, res_illegal packed MSB..LSB
  task automatic check_res(input string tag, input logic [3:0] exp, input int unsigned mp,
                           input int unsigned mp_s);
    check_val({tag, "_res"}, {28'd0, res_valid, res_taken, res_mispredict, res_illegal}, {28'd0, exp});
    check_val({tag, "_mp"}, {16'd0, mp_count}, mp);
    check_val({tag, "_mp_sat"}, {30'd0, s_mp_count}, mp_s);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    lk_pc = PC_A;
    br_valid = 1'b0; br_pc = '0; br_opcode = '0; br_funct3 = '0;
    br_rs1 = '0; br_rs2 = '0; br_pred = 1'b0;
    tick(); tick();
    check_res("reset", 4'b0000, 0, 0);
    check_val("reset_lk", {31'd0, lk_taken}, 0);
    rst_n = 1'b1;
    tick();

    // BEQ 5==5 predicted NT: mispredict, entry 01->10; bypass visible before the edge
    set_br(OPB, 3'b000, 32'd5, 32'd5, PC_A, 1'b0);
    lk_pc = PC_A;
    #1 check_val("beq_bypass_lk", {31'd0, lk_taken}, 1);
    lk_pc = PC_B;
    #1 check_val("beq_other_idx_lk", {31'd0, lk_taken}, 0);
    tick();
    br_valid = 1'b0;
    check_res("beq", 4'b1110, 1, 1);
    lk_pc = PC_A;
    #1 check_val("beq_entry_lk", {31'd0, lk_taken}, 1);
    // BNE 5!=5 -> NT, predicted T: entry 10->01
    set_br(OPB, 3'b001, 32'd5, 32'd5, PC_A, 1'b1);
    tick();
    br_valid = 1'b0;
    check_res("bne", 4'b1010, 2, 2);
    #1 check_val("bne_entry_lk", {31'd0, lk_taken}, 0);

    // Back-to-back: BLT -1 < 1 signed taken, then BLTU same operands not taken
    set_br(OPB, 3'b100, 32'hFFFF_FFFF, 32'd1, PC_B, 1'b1);
    tick();
    check_res("blt", 4'b1100, 2, 2);
    set_br(OPB, 3'b110, 32'hFFFF_FFFF, 32'd1, PC_B, 1'b1);
    tick();
    br_valid = 1'b0;
    check_res("bltu", 4'b1010, 3, 3);
    lk_pc = PC_B;
    #1 check_val("blt_bltu_lk", {31'd0, lk_taken}, 0);

    // Three taken BGE at PC_C: 01->10->11->11
    lk_pc = PC_C;
    for (int unsigned i = 0; i < 3; i++) begin
      set_br(OPB, 3'b101, 32'd3, 32'd3, PC_C, 1'b1);
      tick();
    end
    br_valid = 1'b0;
    check_res("bge3", 4'b1100, 3, 3);
    #1 check_val("bge3_lk", {31'd0, lk_taken}, 1);
    // BGEU 1>=2 unsigned false: 11->10, still predicts taken
    set_br(OPB, 3'b111, 32'd1, 32'd2, PC_C, 1'b1);
    tick();
    br_valid = 1'b0;
    check_res("bgeu", 4'b1010, 4, 3);
    #1 check_val("bgeu_sat_lk", {31'd0, lk_taken}, 1);

    // Same-index lookup/update at PC_D (entry 01): fifth mispredict
    set_br(OPB, 3'b000, 32'd1, 32'd1, PC_D, 1'b0);
    lk_pc = PC_D;
    #1 check_val("bypass_lk", {31'd0, lk_taken}, 1);
    tick();
    br_valid = 1'b0;
    check_res("bypass", 4'b1110, 5, 3);

    // Illegal funct3 010 at PC_D (entry 10): flagged, table untouched
    set_br(OPB, 3'b010, 32'd1, 32'd1, PC_D, 1'b1);
    tick();
    br_valid = 1'b0;
    check_res("illegal", 4'b1001, 5, 3);
    #1 check_val("illegal_lk", {31'd0, lk_taken}, 1);
    tick();
    check_res("idle_after_illegal", 4'b0000, 5, 3);
    set_br(OPB, 3'b001, 32'd1, 32'd1, PC_D, 1'b0);
    tick();
    br_valid = 1'b0;
    #1 check_val("illegal_unchanged_lk", {31'd0, lk_taken}, 0);

    // Non-branch opcode: no result, no state change
    set_br(OPR, 3'b000, 32'd1, 32'd1, PC_D, 1'b0);
    tick();
    br_valid = 1'b0;
    check_res("nonbranch", 4'b0000, 5, 3);
    #1 check_val("nonbranch_lk", {31'd0, lk_taken}, 0);

    // Reset asserted mid-cycle with a request in flight
    set_br(OPB, 3'b000, 32'd1, 32'd1, PC_C, 1'b0);
    tick();
    set_br(OPB, 3'b000, 32'd1, 32'd1, PC_C, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_res("async_rst", 4'b0000, 0, 0);
    tick();
    br_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_res("post_rst", 4'b0000, 0, 0);
    lk_pc = PC_C;
    #1 check_val("post_rst_lk", {31'd0, lk_taken}, 0);
    // Entry back at 01: one taken makes it predict taken
    set_br(OPB, 3'b000, 32'd2, 32'd2, PC_C, 1'b1);
    tick();
    br_valid = 1'b0;
    check_res("post_rst_br", 4'b1100, 0, 0);
    #1 check_val("post_rst_entry_lk", {31'd0, lk_taken}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of 2-bit history counters, a power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16: width of the mispredict statistics counter.
REQ-004 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port lk_pc, input, XLEN: fetch-stage lookup PC.
REQ-007 SHALL have port lk_taken, output, 1: predicted direction for lk_pc (combinational).
REQ-008 SHALL have port br_valid, input, 1: a resolve request is present this cycle.
REQ-009 SHALL have port br_pc, input, XLEN: PC of the instruction being resolved.
REQ-010 SHALL have ports br_opcode (input, 7) and br_funct3 (input, 3): the instruction fields.
REQ-011 SHALL have ports br_rs1 and br_rs2, input, XLEN each: the compare operands.
REQ-012 SHALL have port br_pred, input, 1: the direction that was predicted earlier for this instruction.
REQ-013 SHALL have port res_valid, output, 1: the resolve result is valid (registered).
REQ-014 SHALL have port res_taken, output, 1: the actual branch direction (registered).
REQ-015 SHALL have port res_mispredict, output, 1: res_taken differs from br_pred (registered).
REQ-016 SHALL have port res_illegal, output, 1: br_funct3 was 010 or 011 on a branch opcode (registered).
REQ-017 SHALL have port mp_count, output, CNT_W: mispredict count, saturating.

Function
REQ-018 SHALL index the history table with IDX = br_pc / lk_pc bits [log2(BHT_DEPTH)+1 : 2].
REQ-019 SHALL hold in each table entry a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-020 SHALL drive lk_taken from bit 1 of the entry at the lookup index.
REQ-021 SHALL, when lk_pc and an update in the same cycle map to the same index, drive lk_taken from the post-update counter value (bypass).
REQ-022 SHALL treat only br_opcode = 1100011 as a branch.
REQ-023 SHALL compute the branch condition at full XLEN width: BEQ rs1==rs2; BNE rs1!=rs2; BLT signed <; BGE signed >=; BLTU unsigned <; BGEU unsigned >=.
REQ-024 SHALL, for a valid branch with legal funct3, assert res_valid one cycle after br_valid, with res_taken = condition and res_mispredict = condition XOR br_pred.
REQ-025 SHALL, for a valid branch with illegal funct3, assert res_valid with res_illegal=1, res_taken=0 and res_mispredict=0, and leave the table unchanged.
REQ-026 SHALL, for a valid request with a non-branch opcode, keep res_valid low and change no state.
REQ-027 SHALL drive all res_* outputs to 0 in any cycle following one without a valid legal or illegal branch.
REQ-028 SHALL update the table at the clock edge that registers the result: increment toward 11 if taken, decrement toward 00 if not taken.
REQ-029 SHALL saturate the counters: 11 stays 11 on taken and 00 stays 00 on not-taken.
REQ-030 SHALL increment mp_count on each res_mispredict event.
REQ-031 SHALL hold mp_count at all-ones once it saturates, with no wrap-around.
REQ-032 SHALL accept back-to-back requests every cycle, each resolving and updating independently, with no stall.

Reset
REQ-033 SHALL, on rst_n low, asynchronously set every table entry to 01 (weak-NT).
REQ-034 SHALL, on rst_n low, asynchronously set res_valid, res_taken, res_mispredict, res_illegal and mp_count to 0.
REQ-035 SHALL discard any request in flight when reset asserts, producing no result and no update after reset releases.

Structure
REQ-036 SHALL place the opcode constant, the funct3 encodings and the counter state encodings in a shared package, branch_pkg.
REQ-037 SHALL implement the condition logic as one combinational sub-module, branch_compare (inputs funct3, rs1, rs2; outputs taken and illegal).
REQ-038 SHALL implement the table as flops, with no memory macro.

Verification
REQ-039 SHALL cover: reset, then BEQ rs1=5 rs2=5 with br_pred=0 -> next cycle res_taken=1, res_mispredict=1, mp_count=1, entry goes 01->10.
REQ-040 SHALL cover: BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU with the same operands -> not taken.
REQ-041 SHALL cover: three consecutive taken branches at one PC -> entry 01->10->11->11, and lk_taken=1 on that PC.
REQ-042 SHALL cover: lookup and update at the same index in the same cycle -> lk_taken reflects the updated value.
REQ-043 SHALL cover: funct3=010 on a branch opcode -> res_illegal=1, table unchanged; opcode 0110011 -> res_valid=0.
REQ-044 SHALL cover: with CNT_W=2, five mispredicts -> mp_count stays at 3; rst_n pulsed mid-stream -> all outputs 0 and all entries 01.
